perf_readout: RTL and testbench

PERF_READOUT -- requirements
Module: perf_readout

---
 rtl/perf_pkg.sv | 13 +
 rtl/perf_snap_regfile.sv | 46 ++++
 rtl/perf_readout.sv | 110 +++++++++++
 tb/tb_perf_readout.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter readout block:
// FSM state encoding and the snapshot sequence-number width.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int PERF_SEQ_W = 8;

endpackage

// File: rtl/perf_snap_regfile.sv
// Snapshot storage: NUM_CNT counter values plus overflow flags, loaded in
// parallel on one edge and read back through an index mux.
module perf_snap_regfile #(
  parameter int NUM_CNT = 8,
  parameter int WIDTH   = 32,
  parameter int AW      = $clog2(NUM_CNT) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [NUM_CNT*WIDTH-1:0] cnt_val,
  input  logic [NUM_CNT-1:0]       cnt_ovf,
  input  logic [AW-1:0]            rd_idx,
  output logic [WIDTH-1:0]         rd_val,
  output logic                     rd_flag,
  output logic                     rd_in_range
);

  localparam int IW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam logic [AW-1:0] NUM_IDX = AW'(NUM_CNT);

  logic [WIDTH-1:0]   vals [NUM_CNT];
  logic [NUM_CNT-1:0] flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) vals[i] <= '0;
      flags <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_CNT; i++) vals[i] <= cnt_val[i*WIDTH +: WIDTH];
      flags <= cnt_ovf;
    end
  end

  // Out-of-range indices read as zero so the caller only needs the range bit.
  always_comb begin
    rd_in_range = (rd_idx < NUM_IDX);
    rd_val      = '0;
    rd_flag     = 1'b0;
    if (rd_in_range) begin
      rd_val  = vals[rd_idx[IW-1:0]];
      rd_flag = flags[rd_idx[IW-1:0]];
    end
  end

endmodule

// File: rtl/perf_readout.sv
// Atomic snapshot of a bank of performance counters with a registered,
// acknowledge-held read port. Current FSM state is exported on fsm_state.
module perf_readout
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 8,
  parameter int WIDTH   = 32,
  parameter int AW      = $clog2(NUM_CNT) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CNT*WIDTH-1:0] cnt_val,
  input  logic [NUM_CNT-1:0]       cnt_ovf,
  input  logic                     snap_req,
  output logic                     snap_ready,
  output logic [PERF_SEQ_W-1:0]    snap_seq,
  input  logic                     rd_req,
  input  logic [AW-1:0]            rd_addr,
  output logic                     rd_gnt,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_ovf,
  output logic                     rd_err,
  input  logic                     rd_ack,
  output state_e                   fsm_state
);

  // Handshakes: a snapshot is taken on any edge where snap_req & snap_ready;
  // a read is taken on any edge where rd_gnt. The response then holds
  // rd_valid and its payload until an edge with rd_ack (RESP state only).

  state_e             state, state_nxt;
  logic               have_snap;
  logic               snap_take;
  logic [WIDTH-1:0]   sel_val;
  logic               sel_flag;
  logic               sel_in_range;
  logic               resp_ok;

  assign fsm_state  = state;
  assign snap_ready = (state != RESP);
  assign snap_take  = snap_req & snap_ready;
  // Snapshot wins over a read arriving in the same cycle.
  assign rd_gnt     = rd_req & snap_ready & ~snap_req;
  assign resp_ok    = (state == HOLD) & sel_in_range;

  perf_snap_regfile #(
    .NUM_CNT (NUM_CNT),
    .WIDTH   (WIDTH),
    .AW      (AW)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .load        (snap_take),
    .cnt_val     (cnt_val),
    .cnt_ovf     (cnt_ovf),
    .rd_idx      (rd_addr),
    .rd_val      (sel_val),
    .rd_flag     (sel_flag),
    .rd_in_range (sel_in_range)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HOLD: begin
        if (snap_take)   state_nxt = HOLD;
        else if (rd_gnt) state_nxt = RESP;
      end
      RESP: begin
        if (rd_ack) state_nxt = have_snap ? HOLD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      have_snap <= 1'b0;
      snap_seq  <= '0;
    end else begin
      state <= state_nxt;
      if (snap_take) begin
        have_snap <= 1'b1;
        snap_seq  <= snap_seq + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
      rd_err   <= 1'b0;
    end else if (rd_gnt) begin
      rd_valid <= 1'b1;
      rd_data  <= resp_ok ? sel_val : '0;
      rd_ovf   <= resp_ok ? sel_flag : 1'b0;
      rd_err   <= ~resp_ok;
    end else if ((state == RESP) && rd_ack) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
      rd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_perf_readout.sv
// Randomized and directed bench for perf_readout (NUM_CNT=4, WIDTH=32) with
// a reference model of the snapshot/read rules and a response scoreboard.
module tb_perf_readout;
  import perf_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 3;
  localparam int EW = W + 2;

  logic             clk;
  logic             rst;
  logic [N*W-1:0]   cnt_val;
  logic [N-1:0]     cnt_ovf;
  logic             snap_req;
  logic             snap_ready;
  logic [7:0]       snap_seq;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_gnt;
  logic             rd_valid;
  logic [W-1:0]     rd_data;
  logic             rd_ovf;
  logic             rd_err;
  logic             rd_ack;
  state_e           fsm_state;

  perf_readout #(.NUM_CNT(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_val    (cnt_val),
    .cnt_ovf    (cnt_ovf),
    .snap_req   (snap_req),
    .snap_ready (snap_ready),
    .snap_seq   (snap_seq),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ovf     (rd_ovf),
    .rd_err     (rd_err),
    .rd_ack     (rd_ack),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [W-1:0]  snap_m [N];
  logic          flag_m [N];
  bit            have_m;
  bit            resp_m;
  int            seq_m;
  logic [EW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      snap_m[i] = '0;
      flag_m[i] = 1'b0;
    end
    have_m = 0;
    resp_m = 0;
    seq_m  = 0;
    exp_q.delete();
  endtask

  function automatic logic [EW-1:0] expect_resp(input int addr);
    if (have_m && addr < N) return {1'b0, flag_m[addr], snap_m[addr]};
    return {1'b1, 1'b0, {W{1'b0}}};
  endfunction

  // driver: called at a negedge, returns at the next negedge
  task automatic cycle(input logic s, input logic r, input int a, input logic k);
    bit exp_gnt;
    snap_req = s;
    rd_req   = r;
    rd_addr  = AW'(a);
    rd_ack   = k;
    #1;
    exp_gnt = r && !resp_m && !s;
    check("snap_ready", 64'(snap_ready), 64'(!resp_m));
    check("rd_gnt", 64'(rd_gnt), 64'(exp_gnt));
    check("snap_seq", 64'(snap_seq), 64'(seq_m));
    @(posedge clk);
    if (resp_m) begin
      if (k) resp_m = 0;
    end else if (s) begin
      for (int i = 0; i < N; i++) begin
        snap_m[i] = cnt_val[i*W +: W];
        flag_m[i] = cnt_ovf[i];
      end
      have_m = 1;
      seq_m  = (seq_m + 1) % 256;
    end else if (r) begin
      exp_q.push_back(expect_resp(a));
      resp_m = 1;
    end
    @(negedge clk);
    snap_req = 1'b0;
    rd_req   = 1'b0;
    rd_ack   = 1'b0;
  endtask

  task automatic set_cnt(input int idx, input logic [W-1:0] v);
    cnt_val[idx*W +: W] = v;
  endtask

  // monitor / scoreboard
  logic          prev_valid;
  logic [EW-1:0] held;
  initial begin
    prev_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rd_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected: got=0x%0h want=none", {rd_err, rd_ovf, rd_data});
        end else begin
          check("resp", 64'({rd_err, rd_ovf, rd_data}), 64'(exp_q.pop_front()));
        end
        held = {rd_err, rd_ovf, rd_data};
      end else if (rd_valid) begin
        check("resp_stable", 64'({rd_err, rd_ovf, rd_data}), 64'(held));
      end else begin
        check("idle_outputs", 64'({rd_err, rd_ovf, rd_data}), 64'(0));
      end
      prev_valid = rd_valid;
    end
  end

  initial begin
    rst = 1'b1;
    cnt_val = '0;
    cnt_ovf = '0;
    snap_req = 1'b0;
    rd_req = 1'b0;
    rd_addr = '0;
    rd_ack = 1'b0;
    model_reset();
    #2;
    check("rst_valid", 64'(rd_valid), 64'(0));
    check("rst_seq", 64'(snap_seq), 64'(0));
    check("rst_ready", 64'(snap_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // read before any snapshot -> error response
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);

    // snapshot isolates live counter changes
    set_cnt(2, 32'h0000_1234);
    cycle(1, 0, 0, 0);
    set_cnt(2, 32'hFFFF_FFFF);
    cycle(0, 1, 2, 0);
    cycle(0, 0, 0, 1);
    check("seq_after_first", 64'(snap_seq), 64'(1));

    // snapshot beats a simultaneous read, read granted next cycle
    cycle(1, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 1);

    // bad index, response held without ack; snapshot refused in RESP
    cycle(0, 1, 5, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);

    // 256 snapshots wrap the sequence; overflow flag captured
    cnt_ovf = 4'b0010;
    for (int i = 0; i < 256; i++) begin
      if (seq_m == 255) begin
        cycle(1, 0, 0, 0);
        check("seq_wrap", 64'(snap_seq), 64'(0));
      end else begin
        cycle(1, 0, 0, 0);
      end
    end
    cnt_ovf = '0;
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 1);

    // asynchronous reset during a pending response
    cycle(0, 1, 2, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(rd_valid), 64'(0));
    check("rst_mid_data", 64'({rd_err, rd_ovf, rd_data}), 64'(0));
    check("rst_mid_seq", 64'(snap_seq), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 1, 2, 0);
    cycle(0, 0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) set_cnt($urandom_range(0, N - 1), $urandom);
      if ($urandom_range(0, 3) == 0) cnt_ovf = N'($urandom);
      cycle(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), ($urandom_range(0, 2) != 0));
    end

    // drain any outstanding response
    for (int i = 0; i < 4 && resp_m; i++) cycle(0, 0, 0, 1);
    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    check("drained", 64'(rd_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
